// File: rtl/nibble_add_tester_if.sv
// Operand/result bus between the nibble-adder tester and the adder under test.
// Ports: op_out carries operands {A[7:4], B[3:0]}; res_in carries the adder's 8-bit result.
// master = tester side, slave = adder side.
interface nibble_add_tester_if;
  logic [7:0] op_out;
  logic [7:0] res_in;

  modport master (output op_out, input res_in);
  modport slave  (input op_out, output res_in);
endinterface

// File: rtl/nibble_add_tester.sv
// Self-test initiator for the registered nibble adder: sweeps all 256 operand
// pairs, checks each result against {4'b0, (A+B) mod 16}, and reports
// pass, a saturating mismatch count and the first failing operand.
// Ports: clk, reset (sync, active-high), start, bus (op_out/res_in),
//        busy, done, pass, err_count, first_fail, fail_valid.
module nibble_add_tester #(
  parameter int LATENCY = 1  // edges from operand on op_out to result on res_in (1..4)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  nibble_add_tester_if.master         bus,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [7:0]                  err_count,
  output logic [7:0]                  first_fail,
  output logic                        fail_valid
);

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

  state_t state, state_nxt;
  logic   launch;

  logic [7:0] op_q;
  logic [2:0] drain_cnt;

  // Expected pipeline: stage 0 holds the operand just placed on op_out,
  // stage LATENCY holds the operand whose result is on res_in right now.
  logic [LATENCY:0][7:0] pipe_op;
  logic [LATENCY:0]      pipe_vld;

  logic       push;
  logic [7:0] push_op;
  logic [7:0] chk_op;
  logic [3:0] exp_sum;
  logic       mismatch;
  logic [7:0] err_nxt;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          launch    = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        busy = 1'b1;
        if (op_q == 8'hFF) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == 3'(LATENCY - 1)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- Datapath ----------------
  // A new operand is launched on the start edge (0x00) and on every DRIVE
  // edge until 0xFF has been driven.
  assign push    = launch || (state == DRIVE && op_q != 8'hFF);
  assign push_op = launch ? 8'h00 : op_q + 8'd1;

  assign chk_op   = pipe_op[LATENCY];
  assign exp_sum  = chk_op[7:4] + chk_op[3:0];  // 4-bit wrap is the mod-16 rule
  assign mismatch = pipe_vld[LATENCY] && (bus.res_in != {4'h0, exp_sum});
  assign err_nxt  = (mismatch && err_count != 8'hFF) ? err_count + 8'd1 : err_count;

  assign bus.op_out = op_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= 8'h00;
      drain_cnt  <= 3'd0;
      pipe_op    <= '0;
      pipe_vld   <= '0;
      err_count  <= 8'h00;
      first_fail <= 8'h00;
      fail_valid <= 1'b0;
      pass       <= 1'b0;
    end else begin
      pipe_op  <= {pipe_op[LATENCY-1:0], push_op};
      pipe_vld <= {pipe_vld[LATENCY-1:0], push};

      if (push)                op_q <= push_op;
      else if (state == DRIVE) op_q <= 8'h00;  // leaving DRIVE after 0xFF

      if (state == DRAIN) drain_cnt <= drain_cnt + 3'd1;
      else                drain_cnt <= 3'd0;

      if (launch) begin
        // pipeline is empty here, so no compare can collide with the clear
        err_count  <= 8'h00;
        first_fail <= 8'h00;
        fail_valid <= 1'b0;
        pass       <= 1'b0;
      end else begin
        err_count <= err_nxt;
        if (mismatch && !fail_valid) begin
          first_fail <= chk_op;
          fail_valid <= 1'b1;
        end
        // last compare lands on the DONE-entry edge, so use the updated count
        if (state == DRAIN && state_nxt == DONE) pass <= (err_nxt == 8'h00);
      end
    end
  end

endmodule

// File: tb/tb_nibble_add_tester.sv
module tb_nibble_add_tester;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start1, start3;
  logic busy1, done1, pass1, fv1, busy3, done3, pass3, fv3;
  logic [7:0] err1, first1, err3, first3;

  nibble_add_tester_if if1 ();
  nibble_add_tester_if if3 ();

  nibble_add_tester #(.LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .bus(if1.master),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail(first1), .fail_valid(fv1));

  nibble_add_tester #(.LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .bus(if3.master),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .first_fail(first3), .fail_valid(fv3));

  // ---------------- adder models ----------------
  // mode 0 ideal, 1 bit0 stuck at 0, 2 unmasked 5-bit sum, 3 constant 0xFF,
  // 4 ideal XOR a per-operand random corruption mask
  int mode1, depth1, mode3;
  logic [7:0] rmask [256];
  logic [3:0][7:0] p1, p3;

  function automatic logic [7:0] adder_f(input int mode, input logic [7:0] k);
    int a, b, s;
    a = int'(k[7:4]);
    b = int'(k[3:0]);
    s = a + b;
    case (mode)
      0: return 8'(s % 16);
      1: return 8'(s % 16) & 8'hFE;
      2: return 8'(s);
      3: return 8'hFF;
      default: return 8'(s % 16) ^ rmask[k];
    endcase
  endfunction

  always @(posedge clk) begin
    p1 <= {p1[2:0], if1.op_out};
    p3 <= {p3[2:0], if3.op_out};
  end
  assign if1.res_in = adder_f(mode1, (depth1 == 3) ? p1[2] : p1[0]);
  assign if3.res_in = adder_f(mode3, p3[2]);

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: sweep every operand pair once with plain arithmetic.
  task automatic ref_model(input int mode, output int err, output int first,
                           output int fv, output int pss);
    int cnt;
    cnt = 0; first = 0; fv = 0;
    for (int k = 0; k < 256; k++) begin
      int want;
      want = ((k / 16) + (k % 16)) % 16;
      if (int'(adder_f(mode, 8'(k))) != want) begin
        cnt++;
        if (fv == 0) begin first = k; fv = 1; end
      end
    end
    err = (cnt > 255) ? 255 : cnt;
    pss = (cnt == 0) ? 1 : 0;
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 1) start1 = v; else start3 = v;
  endtask

  // Pulse start, check the start-edge clearing, then count edges to done.
  task automatic run(input int sel, input int exp_edges, input int repulse_at, input string tag);
    int edges;
    bit seen, busy_bad;
    @(negedge clk);
    set_start(sel, 1'b1);
    @(posedge clk);
    #1;
    set_start(sel, 1'b0);
    check({tag, "_e0_busy"}, int'(sel == 1 ? busy1 : busy3), 1);
    check({tag, "_e0_err"},  int'(sel == 1 ? err1 : err3), 0);
    check({tag, "_e0_fv"},   int'(sel == 1 ? fv1 : fv3), 0);
    edges = 0; seen = 0; busy_bad = 0;
    while (!seen && edges < 1000) begin
      set_start(sel, (edges + 1 == repulse_at) ? 1'b1 : 1'b0);
      @(posedge clk);
      #1;
      edges++;
      if ((sel == 1 ? done1 : done3) == 1'b1) seen = 1;
      else if ((sel == 1 ? busy1 : busy3) == 1'b0) busy_bad = 1;
    end
    set_start(sel, 1'b0);
    check({tag, "_done_edge"}, edges, exp_edges);
    check({tag, "_busy_run"}, int'(busy_bad), 0);
    check({tag, "_busy_done"}, int'(sel == 1 ? busy1 : busy3), 0);
  endtask

  task automatic check_results(input int sel, input string tag, input int err,
                               input int first, input int fv, input int pss);
    if (err >= 0) check({tag, "_err"}, int'(sel == 1 ? err1 : err3), err);
    if (fv != 0)  check({tag, "_first"}, int'(sel == 1 ? first1 : first3), first);
    check({tag, "_fv"},   int'(sel == 1 ? fv1 : fv3), fv);
    check({tag, "_pass"}, int'(sel == 1 ? pass1 : pass3), pss);
  endtask

  typedef struct {
    int sel; int mode; int depth; int edges;
    int err; int first; int fv; int pss; string name;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e, f, v, p;
    tbl[0] = '{1, 0, 1, 257, 0,   8'h00, 0, 1, "ideal"};
    tbl[1] = '{1, 1, 1, 257, 128, 8'h01, 1, 0, "stuck0"};
    tbl[2] = '{1, 2, 1, 257, 120, 8'h1F, 1, 0, "unmasked"};
    tbl[3] = '{1, 3, 1, 257, 255, 8'h00, 1, 0, "all_ff"};
    tbl[4] = '{3, 0, 3, 259, 0,   8'h00, 0, 1, "lat3"};
    tbl[5] = '{1, 0, 3, 257, -1,  8'h01, 1, 0, "lat_mismatch"};

    reset = 1'b1; start1 = 1'b0; start3 = 1'b0;
    mode1 = 0; depth1 = 1; mode3 = 0;
    for (int k = 0; k < 256; k++) rmask[k] = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    check("rst_op1",   int'(if1.op_out), 0);
    check("rst_busy1", int'(busy1), 0);
    check("rst_done1", int'(done1), 0);
    check("rst_pass1", int'(pass1), 0);
    check("rst_err1",  int'(err1), 0);
    check("rst_first1", int'(first1), 0);
    check("rst_fv1",   int'(fv1), 0);
    check("rst_done3", int'(done3), 0);
    @(negedge clk);
    reset = 1'b0;

    // ---- test-plan scenarios ----
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].sel == 1) begin mode1 = tbl[i].mode; depth1 = tbl[i].depth; end
      else mode3 = tbl[i].mode;
      run(tbl[i].sel, tbl[i].edges, 0, tbl[i].name);
      check_results(tbl[i].sel, tbl[i].name, tbl[i].err, tbl[i].first, tbl[i].fv, tbl[i].pss);
    end
    depth1 = 1;

    // ---- randomized corruption patterns against the reference ----
    for (int r = 0; r < 4; r++) begin
      int sel;
      sel = (r % 2 == 1) ? 3 : 1;
      for (int k = 0; k < 256; k++) begin
        if (r == 2 || $urandom_range(0, 7) == 0) rmask[k] = 8'($urandom_range(1, 255));
        else rmask[k] = 8'h00;
      end
      if (sel == 1) mode1 = 4; else mode3 = 4;
      ref_model(4, e, f, v, p);
      run(sel, (sel == 1) ? 257 : 259, 0, $sformatf("rand%0d", r));
      check_results(sel, $sformatf("rand%0d", r), e, f, v, p);
    end
    mode3 = 0;

    // ---- start re-pulsed during DRIVE is ignored ----
    mode1 = 0;
    run(1, 257, 50, "repulse");
    check_results(1, "repulse", 0, 0, 0, 1);
    @(negedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("hold_done", int'(done1), 1);
    check("hold_pass", int'(pass1), 1);

    // ---- failing run, then restart from DONE clears results ----
    mode1 = 3;
    run(1, 257, 0, "pre_restart");
    check_results(1, "pre_restart", 255, 0, 1, 0);
    mode1 = 0;
    run(1, 257, 0, "restart");
    check_results(1, "restart", 0, 0, 0, 1);

    // ---- reset at E100 mid-run ----
    mode1 = 3;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    check("mid_err_before", int'(err1 != 8'h00), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_op",   int'(if1.op_out), 0);
    check("mid_rst_busy", int'(busy1), 0);
    check("mid_rst_done", int'(done1), 0);
    check("mid_rst_err",  int'(err1), 0);
    check("mid_rst_fv",   int'(fv1), 0);
    check("mid_rst_first", int'(first1), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_rst_busy", int'(busy1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
